bram_stream_reader: RTL and testbench

- Read-side sequencer placed directly downstream of the 1-cycle-latency simple dual-port block RAM.
- Accepts a command (base address, word count) and drives the RAM read address port with consecutive addresses.
- Captures the registered RAM output and presents the words as a valid/ready stream with a last marker.
- Absorbs the RAM read latency and consumer backpressure with a small internal FIFO.

---
 rtl/bram_stream_reader.sv | 163 ++++++++++++++++
 tb/tb_bram_stream_reader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// Read-side sequencer for a 1-cycle-latency block RAM. It turns a (base, count)
// command into consecutive reads and replays the words as a valid/ready stream.
module bram_stream_reader #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 11,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] cmd_base,
  input  logic [ADDRESS_WIDTH:0]   cmd_count,
  output logic [ADDRESS_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0]    rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W:0]   ISSUE_LIMIT = (CNT_W + 1)'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDRESS_WIDTH-1:0] raddr_q;
  logic [ADDRESS_WIDTH:0]   remain_q;

  // Two-stage in-flight tags: stage 1 = address on the RAM port, stage 2 = rdata valid.
  logic v1_q, l1_q, v2_q, l2_q;

  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic                  fifo_last_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      fifo_cnt_q;

  logic             accept, accept_issue, run_issue, do_issue, issue_last;
  logic             issue_permit, push, pop, drain_done;
  logic [1:0]       inflight;
  logic [CNT_W:0]   pending;

  always_comb begin
    inflight     = {1'b0, v1_q} + {1'b0, v2_q};
    pending      = {1'b0, fifo_cnt_q} + (CNT_W + 1)'(inflight);
    issue_permit = (pending <= ISSUE_LIMIT);
    out_valid    = (fifo_cnt_q != '0);
    push         = v2_q;
    pop          = out_valid && out_ready;
    accept       = cmd_valid && cmd_ready;
    accept_issue = accept && (cmd_count != '0);
    issue_last   = accept_issue ? (cmd_count == (ADDRESS_WIDTH + 1)'(1))
                                : (remain_q == (ADDRESS_WIDTH + 1)'(1));
    drain_done   = !v1_q && !v2_q &&
                   ((fifo_cnt_q == '0) || ((fifo_cnt_q == CNT_W'(1)) && pop));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_issue) begin
          state_d = issue_last ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (run_issue && issue_last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The accepting edge is itself the first issue, so cmd_base is on raddr one cycle later.
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    run_issue = (state_q == S_ISSUE) && issue_permit;
    do_issue  = accept_issue || run_issue;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      raddr_q  <= '0;
      remain_q <= '0;
      v1_q     <= 1'b0;
      l1_q     <= 1'b0;
      v2_q     <= 1'b0;
      l2_q     <= 1'b0;
    end else begin
      if (do_issue) begin
        raddr_q <= accept_issue ? cmd_base : raddr_q + 1'b1;
      end
      if (accept_issue) begin
        remain_q <= cmd_count - 1'b1;
      end else if (run_issue) begin
        remain_q <= remain_q - 1'b1;
      end
      v1_q <= do_issue;
      l1_q <= do_issue && issue_last;
      v2_q <= v1_q;
      l2_q <= l1_q;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= rdata;
      fifo_last_q[wr_ptr_q] <= l2_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Head is masked while empty so stale storage never appears on the stream.
  always_comb begin
    raddr    = raddr_q;
    out_data = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    out_last = out_valid ? fifo_last_q[rd_ptr_q] : 1'b0;
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: a 1-cycle RAM model plus a queue-based reference
// (expected word k of a command is mem[(base + k) mod 2048]).
module tb_bram_stream_reader;

  localparam int DW   = 16;
  localparam int AW   = 11;
  localparam int DEP  = 4;
  localparam int MEMN = 2048;

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_count;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  logic [DW-1:0] mem [MEMN];

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] got_data [$];
  logic          got_last [$];
  int            got_cyc  [$];
  logic [AW-1:0] got_raddr [$];
  int            stall_viol;
  int            ready_viol;
  int            occ_max;
  int            end_k;
  int            accept_wait;
  bit            timed_out;

  always #5 clock = ~clock;

  always @(posedge clock) rdata <= mem[raddr];

  bram_stream_reader #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .FIFO_DEPTH   (DEP)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_base (cmd_base),
    .cmd_count(cmd_count),
    .raddr    (raddr),
    .rdata    (rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] ref_word(input int base, input int k);
    return mem[(base + k) % MEMN];
  endfunction

  // Presents one command, then records every popped beat with its cycle index
  // k (sample taken in the cycle after accept edge T+k) until busy falls.
  task automatic run_cmd(input logic [AW-1:0] base, input logic [AW:0] count,
                         input int mode, input int max_cyc, input bit hold_next,
                         input logic [AW-1:0] nbase, input logic [AW:0] ncount);
    int k;
    logic pv, pr, pl;
    logic [DW-1:0] pd;
    got_data.delete(); got_last.delete(); got_cyc.delete(); got_raddr.delete();
    stall_viol = 0; ready_viol = 0; occ_max = 0; timed_out = 0; end_k = -1;
    accept_wait = 0;
    cmd_base  = base;
    cmd_count = count;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && accept_wait < max_cyc) begin
      step();
      accept_wait++;
    end
    if (accept_wait >= max_cyc) begin
      timed_out = 1;
      cmd_valid = 1'b0;
      return;
    end
    step();
    if (hold_next) begin
      cmd_base  = nbase;
      cmd_count = ncount;
    end else begin
      cmd_valid = 1'b0;
    end
    pv = 1'b0; pr = 1'b0; pd = '0; pl = 1'b0;
    for (k = 0; k < max_cyc; k++) begin
      got_raddr.push_back(raddr);
      if (int'(dut.fifo_cnt_q) > occ_max) occ_max = int'(dut.fifo_cnt_q);
      if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd || out_last !== pl))
        stall_viol++;
      if (busy !== 1'b1) break;
      if (cmd_ready !== 1'b0) ready_viol++;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((k % 4) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid === 1'b1 && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        got_cyc.push_back(k);
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      step();
    end
    if (k >= max_cyc) timed_out = 1;
    end_k = k;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_count = '0; out_ready = 1'b0;
    repeat (3) step();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    n_cmp++; if (raddr !== '0) begin n_err++; $display("FAIL reset_raddr: got %0d expected 0", raddr); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    reset = 1'b0;
    step();
    n_cmp++; if (cmd_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: got ready=%b valid=%b expected 1/0", cmd_ready, out_valid); end
    $display("reset: checked idle outputs");
  endtask

  task automatic test_basic();
    run_cmd(11'd5, 12'd4, 0, 100, 1'b0, '0, '0);
    n_cmp++; if (timed_out) begin n_err++; $display("FAIL basic_timeout: got timeout expected completion"); end
    n_cmp++; if (got_data.size() != 4) begin n_err++; $display("FAIL basic_count: got %0d expected 4", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 4; i++) begin
      n_cmp++; if (got_data[i] !== ref_word(5, i)) begin n_err++; $display("FAIL basic_data[%0d]: got %h expected %h", i, got_data[i], ref_word(5, i)); end
      n_cmp++; if (got_last[i] !== (i == 3)) begin n_err++; $display("FAIL basic_last[%0d]: got %b expected %b", i, got_last[i], (i == 3)); end
      n_cmp++; if (got_cyc[i] != 2 + i) begin n_err++; $display("FAIL basic_cycle[%0d]: got %0d expected %0d", i, got_cyc[i], 2 + i); end
    end
    if (got_cyc.size() > 0) begin
      n_cmp++; if (end_k != got_cyc[got_cyc.size()-1] + 1) begin n_err++; $display("FAIL basic_busy_drop: got cycle %0d expected %0d", end_k, got_cyc[got_cyc.size()-1] + 1); end
    end
    $display("basic: base=5 count=4 beats=%0d busy_drop=%0d", got_data.size(), end_k);
  endtask

  task automatic test_wrap();
    run_cmd(11'd2046, 12'd4, 0, 100, 1'b0, '0, '0);
    n_cmp++; if (timed_out || got_data.size() != 4) begin n_err++; $display("FAIL wrap_count: got %0d expected 4 (timeout=%0d)", got_data.size(), timed_out); end
    for (int i = 0; i < 4 && i < got_raddr.size(); i++) begin
      n_cmp++; if (int'(got_raddr[i]) != (2046 + i) % MEMN) begin n_err++; $display("FAIL wrap_raddr[%0d]: got %0d expected %0d", i, got_raddr[i], (2046 + i) % MEMN); end
    end
    for (int i = 0; i < got_data.size() && i < 4; i++) begin
      n_cmp++; if (got_data[i] !== ref_word(2046, i) || got_last[i] !== (i == 3)) begin n_err++; $display("FAIL wrap_beat[%0d]: got %h/%b expected %h/%b", i, got_data[i], got_last[i], ref_word(2046, i), (i == 3)); end
    end
    $display("wrap: base=2046 count=4 beats=%0d", got_data.size());
  endtask

  task automatic test_backpressure();
    run_cmd(11'd0, 12'd16, 1, 400, 1'b0, '0, '0);
    n_cmp++; if (timed_out || got_data.size() != 16) begin n_err++; $display("FAIL bp_count: got %0d expected 16 (timeout=%0d)", got_data.size(), timed_out); end
    for (int i = 0; i < got_data.size() && i < 16; i++) begin
      n_cmp++; if (got_data[i] !== ref_word(0, i) || got_last[i] !== (i == 15)) begin n_err++; $display("FAIL bp_beat[%0d]: got %h/%b expected %h/%b", i, got_data[i], got_last[i], ref_word(0, i), (i == 15)); end
    end
    n_cmp++; if (stall_viol != 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_viol); end
    n_cmp++; if (occ_max > DEP) begin n_err++; $display("FAIL bp_occupancy: got %0d expected <= %0d", occ_max, DEP); end
    $display("backpressure: base=0 count=16 beats=%0d max_occ=%0d", got_data.size(), occ_max);
  endtask

  task automatic test_zero_and_full();
    int bad;
    int data_err;
    int last_err;
    int gap_err;
    logic [AW-1:0] b;
    cmd_base = 11'd7; cmd_count = '0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) bad++;
      step();
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL zero_count: got %0d active cycles expected 0", bad); end
    $display("zero_count: active_cycles=%0d", bad);

    b = AW'($urandom_range(0, MEMN - 1));
    run_cmd(b, 12'd2048, 0, 2200, 1'b0, '0, '0);
    n_cmp++; if (timed_out || got_data.size() != 2048) begin n_err++; $display("FAIL full_count: got %0d expected 2048 (timeout=%0d)", got_data.size(), timed_out); end
    data_err = 0; last_err = 0; gap_err = 0;
    for (int i = 0; i < got_data.size(); i++) begin
      if (got_data[i] !== ref_word(int'(b), i)) data_err++;
      if (got_last[i] !== (i == 2047)) last_err++;
      if (got_cyc[i] != 2 + i) gap_err++;
    end
    n_cmp++; if (data_err != 0) begin n_err++; $display("FAIL full_data: got %0d wrong words expected 0", data_err); end
    n_cmp++; if (last_err != 0) begin n_err++; $display("FAIL full_last: got %0d wrong last flags expected 0", last_err); end
    n_cmp++; if (gap_err != 0) begin n_err++; $display("FAIL full_rate: got %0d off-cycle beats expected 0", gap_err); end
    $display("full_range: base=%0d beats=%0d", b, got_data.size());
  endtask

  task automatic test_reset_mid();
    int bad;
    cmd_base = 11'd0; cmd_count = 12'd16; cmd_valid = 1'b1; out_ready = 1'b0;
    while (cmd_ready !== 1'b1) step();
    step();
    cmd_valid = 1'b0;
    repeat (3) step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_buffered: got out_valid=%b expected 1", out_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL mid_reset: got valid=%b ready=%b busy=%b expected 0/1/0", out_valid, cmd_ready, busy); end
    run_cmd(11'd10, 12'd2, 0, 100, 1'b0, '0, '0);
    n_cmp++; if (timed_out || got_data.size() != 2) begin n_err++; $display("FAIL mid_count: got %0d expected 2 (timeout=%0d)", got_data.size(), timed_out); end
    for (int i = 0; i < got_data.size() && i < 2; i++) begin
      n_cmp++; if (got_data[i] !== ref_word(10, i) || got_last[i] !== (i == 1)) begin n_err++; $display("FAIL mid_beat[%0d]: got %h/%b expected %h/%b", i, got_data[i], got_last[i], ref_word(10, i), (i == 1)); end
    end
    bad = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (out_valid !== 1'b0) bad++;
      step();
    end
    out_ready = 1'b0;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL mid_extra: got %0d extra beats expected 0", bad); end
    $display("reset_mid: post-reset beats=%0d extra=%0d", got_data.size(), bad);
  endtask

  task automatic test_back_to_back();
    run_cmd(11'd100, 12'd6, 2, 300, 1'b1, 11'd2040, 12'd12);
    n_cmp++; if (timed_out || got_data.size() != 6) begin n_err++; $display("FAIL b2b_first_count: got %0d expected 6 (timeout=%0d)", got_data.size(), timed_out); end
    for (int i = 0; i < got_data.size() && i < 6; i++) begin
      n_cmp++; if (got_data[i] !== ref_word(100, i) || got_last[i] !== (i == 5)) begin n_err++; $display("FAIL b2b_first[%0d]: got %h/%b expected %h/%b", i, got_data[i], got_last[i], ref_word(100, i), (i == 5)); end
    end
    n_cmp++; if (ready_viol != 0) begin n_err++; $display("FAIL b2b_ready_busy: got %0d ready-while-busy cycles expected 0", ready_viol); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after_last: got %b expected 1", cmd_ready); end
    run_cmd(11'd2040, 12'd12, 2, 300, 1'b0, '0, '0);
    n_cmp++; if (accept_wait != 0) begin n_err++; $display("FAIL b2b_accept_wait: got %0d expected 0", accept_wait); end
    n_cmp++; if (timed_out || got_data.size() != 12) begin n_err++; $display("FAIL b2b_second_count: got %0d expected 12 (timeout=%0d)", got_data.size(), timed_out); end
    for (int i = 0; i < got_data.size() && i < 12; i++) begin
      n_cmp++; if (got_data[i] !== ref_word(2040, i) || got_last[i] !== (i == 11)) begin n_err++; $display("FAIL b2b_second[%0d]: got %h/%b expected %h/%b", i, got_data[i], got_last[i], ref_word(2040, i), (i == 11)); end
    end
    $display("back_to_back: second beats=%0d", got_data.size());
  endtask

  task automatic test_random();
    int errs;
    int base;
    int cnt;
    for (int i = 0; i < MEMN; i++) mem[i] = DW'($urandom);
    for (int t = 0; t < 8; t++) begin
      base = int'($urandom_range(0, MEMN - 1));
      cnt  = int'($urandom_range(1, 40));
      run_cmd(AW'(base), (AW + 1)'(cnt), 2, 1000, 1'b0, '0, '0);
      errs = 0;
      for (int i = 0; i < got_data.size(); i++)
        if (got_data[i] !== ref_word(base, i) || got_last[i] !== (i == cnt - 1)) errs++;
      n_cmp++; if (timed_out || got_data.size() != cnt) begin n_err++; $display("FAIL rand_count[%0d]: got %0d expected %0d (timeout=%0d)", t, got_data.size(), cnt, timed_out); end
      n_cmp++; if (errs != 0) begin n_err++; $display("FAIL rand_data[%0d]: got %0d wrong beats expected 0", t, errs); end
      n_cmp++; if (stall_viol != 0 || occ_max > DEP) begin n_err++; $display("FAIL rand_flow[%0d]: got stalls=%0d occ=%0d expected 0/<=%0d", t, stall_viol, occ_max, DEP); end
      $display("random[%0d]: base=%0d count=%0d beats=%0d", t, base, cnt, got_data.size());
    end
  endtask

  initial begin
    for (int i = 0; i < MEMN; i++) mem[i] = DW'(i + 16'h100);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_and_full();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
